// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit framer.
// The state enum doubles as "what tx_data is carrying this cycle".
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_UNDR,
    ST_IPG
  } eth_state_t;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/eth_tx_crc8.sv
// Reflected CRC-32 register advanced one byte (LSB first) per enabled cycle.
// init has priority over en and reloads the all-ones seed.
module eth_tx_crc8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] crc
);

  // Eight chained single-bit LFSR steps, din[0] first.
  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    logic [31:0] prev;
    logic [31:0] nxt;
    if (gi == 0) begin : g_first
      assign prev = crc;
    end else begin : g_chain
      assign prev = g_bit[gi-1].nxt;
    end
    assign nxt = (prev >> 1) ^ (ETH_CRC_POLY & {32{prev[0] ^ din[gi]}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= ETH_CRC_INIT;
    end else if (init) begin
      crc <= ETH_CRC_INIT;
    end else if (en) begin
      crc <= g_bit[7].nxt;
    end
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Byte-wide Ethernet TX framer: preamble/SFD, payload, zero pad, FCS, IPG.
// Outputs are registered from the next state, so state_reg describes tx_data.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME = 60,
  parameter int IPG_BYTES = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tx_en,
  output logic       tx_er,
  output logic [7:0] tx_data,
  output logic       busy
);

  localparam logic [10:0] MIN_LEN   = 11'(MIN_FRAME);
  localparam logic [7:0]  IPG_LAST  = 8'(IPG_BYTES - 1);
  localparam logic [10:0] COUNT_MAX = 11'h7FF;

  eth_state_t  state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [10:0] byte_count_reg, byte_count_next;
  logic        last_taken_reg, last_taken_next;
  logic        tx_en_next, tx_er_next;
  logic [7:0]  tx_data_next;
  logic        crc_init, crc_en;
  logic [7:0]  crc_din;
  logic [31:0] crc, fcs;
  logic        accept, need_pad;

  assign in_ready = (state_reg == ST_SFD) || ((state_reg == ST_DATA) && !last_taken_reg);
  assign busy     = (state_reg != ST_IDLE);
  assign accept   = in_ready && in_valid;
  assign need_pad = (byte_count_reg < MIN_LEN);
  assign fcs      = ~crc;

  eth_tx_crc8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .din   (crc_din),
    .crc   (crc)
  );

  always_comb begin
    state_next      = state_reg;
    byte_count_next = byte_count_reg;
    last_taken_next = last_taken_reg;
    crc_init        = 1'b0;
    crc_en          = 1'b0;
    crc_din         = in_data;

    case (state_reg)
      ST_IDLE: if (in_valid) state_next = ST_PRE;
      ST_PRE:  if (cnt_reg == 8'd6) state_next = ST_SFD;
      ST_SFD, ST_DATA: begin
        if (last_taken_reg)
          state_next = need_pad ? ST_PAD : ST_FCS;
        else if (in_valid)
          state_next = ST_DATA;
        else
          state_next = ST_UNDR;
      end
      ST_PAD:  if (!need_pad) state_next = ST_FCS;
      ST_FCS:  if (cnt_reg == 8'd3) state_next = ST_IPG;
      ST_UNDR: state_next = ST_IPG;
      // The last gap cycle also serves as the IDLE decision, so a waiting
      // source sees exactly IPG_BYTES dead cycles rather than one extra.
      ST_IPG:  if (cnt_reg == IPG_LAST) state_next = in_valid ? ST_PRE : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    // One shared phase counter: restarts on every state change.
    cnt_next = (state_next != state_reg) ? 8'd0 : cnt_reg + 8'd1;

    if ((state_next == ST_PRE) && (state_reg != ST_PRE)) begin
      crc_init        = 1'b1;
      byte_count_next = '0;
      last_taken_next = 1'b0;
    end

    if (accept && in_last) last_taken_next = 1'b1;

    if ((state_next == ST_DATA) || (state_next == ST_PAD)) begin
      crc_en  = 1'b1;
      crc_din = (state_next == ST_PAD) ? 8'h00 : in_data;
      if (byte_count_reg != COUNT_MAX) byte_count_next = byte_count_reg + 11'd1;
    end

    tx_en_next   = 1'b1;
    tx_er_next   = 1'b0;
    tx_data_next = 8'h00;
    case (state_next)
      ST_IDLE, ST_IPG: tx_en_next   = 1'b0;
      ST_PRE:          tx_data_next = ETH_PREAMBLE;
      ST_SFD:          tx_data_next = ETH_SFD;
      ST_DATA:         tx_data_next = in_data;
      ST_FCS:          tx_data_next = fcs[{cnt_next[1:0], 3'b000} +: 8];
      ST_UNDR:         tx_er_next   = 1'b1;
      default:         tx_data_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      byte_count_reg <= '0;
      last_taken_reg <= 1'b0;
      tx_en          <= 1'b0;
      tx_er          <= 1'b0;
      tx_data        <= 8'h00;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      byte_count_reg <= byte_count_next;
      last_taken_reg <= last_taken_next;
      tx_en          <= tx_en_next;
      tx_er          <= tx_er_next;
      tx_data        <= tx_data_next;
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: default-parameter DUT plus a MIN_FRAME=0 DUT.
// Each cycle's line outputs are traced and then inspected per scenario.
module tb_eth_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid_d, in_valid_np, in_last;
  logic [7:0] in_data;
  logic       d_ready, d_en, d_er, d_busy;
  logic [7:0] d_data;
  logic       n_ready, n_en, n_er, n_busy;
  logic [7:0] n_data;

  eth_tx_framer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d), .in_data(in_data),
    .in_last(in_last), .in_ready(d_ready), .tx_en(d_en), .tx_er(d_er),
    .tx_data(d_data), .busy(d_busy)
  );

  eth_tx_framer #(.MIN_FRAME(0), .IPG_BYTES(12)) dut_np (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_np), .in_data(in_data),
    .in_last(in_last), .in_ready(n_ready), .tx_en(n_en), .tx_er(n_er),
    .tx_data(n_data), .busy(n_busy)
  );

  bit         sel_np;
  logic       m_ready, m_en, m_er, m_busy;
  logic [7:0] m_data;
  assign m_ready = sel_np ? n_ready : d_ready;
  assign m_en    = sel_np ? n_en    : d_en;
  assign m_er    = sel_np ? n_er    : d_er;
  assign m_busy  = sel_np ? n_busy  : d_busy;
  assign m_data  = sel_np ? n_data  : d_data;

  int checks = 0;
  int errors = 0;

  bit         rec;
  bit         tr_en[$], tr_er[$], tr_rdy[$];
  logic [7:0] tr_data[$];
  logic [7:0] pay[$];
  bit         lst[$];

  always @(posedge clk) begin
    #1;
    if (rec) begin
      tr_en.push_back(m_en);
      tr_er.push_back(m_er);
      tr_rdy.push_back(m_ready);
      tr_data.push_back(m_data);
    end
  end

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ b[i]) == 1'b1) r = {1'b0, r[31:1]} ^ 32'hEDB88320;
      else                       r = {1'b0, r[31:1]};
    end
    return r;
  endfunction

  function automatic logic [31:0] residue(input int from, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = from; i < from + n && i < tr_data.size(); i++) c = crc_step(c, tr_data[i]);
    return c;
  endfunction

  function automatic int first_en(input int from);
    for (int i = from; i < tr_en.size(); i++) if (tr_en[i]) return i;
    return -1;
  endfunction

  function automatic int run_len(input int from);
    int n;
    n = 0;
    if (from < 0) return 0;
    for (int i = from; i < tr_en.size() && tr_en[i]; i++) n++;
    return n;
  endfunction

  function automatic int count_er();
    int n;
    n = 0;
    foreach (tr_er[i]) if (tr_er[i]) n++;
    return n;
  endfunction

  function automatic int count_zero(input int from, input int n);
    int z;
    z = 0;
    for (int i = from; i < from + n && i < tr_data.size(); i++) if (tr_data[i] == 8'h00) z++;
    return z;
  endfunction

  task automatic clear_all();
    tr_en.delete(); tr_er.delete(); tr_rdy.delete(); tr_data.delete();
    pay.delete(); lst.delete();
  endtask

  task automatic load_frame(input int n, input logic [7:0] seed);
    for (int i = 0; i < n; i++) begin
      pay.push_back(seed + 8'(i * 7 + 1));
      lst.push_back(i == n - 1);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel_np) in_valid_np = v;
    else        in_valid_d  = v;
  endtask

  // Feeds pay[] honouring in_ready; returns early (valid still high) once
  // stop_after bytes are accepted, if stop_after > 0.
  task automatic send_stream(input int stop_after, output bit ok);
    int idx;
    int guard;
    bit acc;
    idx = 0; guard = 0; ok = 1'b1;
    @(negedge clk);
    rec = 1'b1;
    set_valid(1'b1);
    in_data = pay[0];
    in_last = lst[0];
    while (idx < pay.size()) begin
      acc = m_ready;
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx == stop_after) return;
        if (idx < pay.size()) begin
          in_data = pay[idx];
          in_last = lst[idx];
        end
      end
      guard++;
      if (guard > 3000) begin
        ok = 1'b0;
        break;
      end
    end
    set_valid(1'b0);
    in_last = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int g;
    g = 0;
    while (m_busy && g < 500) begin
      @(negedge clk);
      g++;
    end
    ok = !m_busy;
    repeat (2) @(negedge clk);
    rec = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid_d = 1'b0; in_valid_np = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel_np = s[0];
      #1;
      checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en dut%0d: got %b want 0", s, m_en); end
      checks++; if (m_er !== 1'b0) begin errors++; $display("FAIL reset_tx_er dut%0d: got %b want 0", s, m_er); end
      checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data dut%0d: got %h want 00", s, m_data); end
      checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready dut%0d: got %b want 0", s, m_ready); end
      checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b want 0", s, m_busy); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (d_busy !== 1'b0 || d_en !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy %b tx_en %b want 0 0", d_busy, d_en);
    end
    $display("test_reset done: checks %0d errors %0d", checks, errors);
  endtask

  task automatic test_crc_check();
    string s;
    logic [7:0] exp_q[$];
    bit ok1, ok2;
    int fs, base;
    sel_np = 1'b1;
    clear_all();
    s = "123456789";
    for (int i = 0; i < 9; i++) begin
      pay.push_back(s[i]);
      lst.push_back(i == 8);
    end
    send_stream(0, ok1);
    wait_idle(ok2);
    checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL crc_timeout: send %b idle %b want 1 1", ok1, ok2); end
    fs = first_en(0);
    base = (fs < 0) ? 0 : fs;
    checks++; if (fs != 0) begin errors++; $display("FAIL crc_latency: first tx_en at %0d want 0", fs); end
    checks++; if (run_len(fs) != 21) begin errors++; $display("FAIL crc_frame_len: got %0d want 21", run_len(fs)); end
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 9; i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h26); exp_q.push_back(8'h39); exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
    for (int i = 0; i < 21; i++) begin
      checks++;
      if (tr_data[base + i] !== exp_q[i]) begin
        errors++; $display("FAIL crc_byte[%0d]: got %h want %h", i, tr_data[base + i], exp_q[i]);
      end
    end
    checks++; if (count_er() != 0) begin errors++; $display("FAIL crc_tx_er: high %0d cycles want 0", count_er()); end
    sel_np = 1'b0;
    $display("test_crc_check done: checks %0d errors %0d", checks, errors);
  endtask

  task automatic test_pad();
    bit ok1, ok2;
    int fs, base;
    logic [31:0] r;
    clear_all();
    load_frame(14, 8'h10);
    send_stream(0, ok1);
    wait_idle(ok2);
    checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL pad_timeout: send %b idle %b want 1 1", ok1, ok2); end
    fs = first_en(0);
    base = (fs < 0) ? 0 : fs;
    checks++; if (run_len(fs) != 72) begin errors++; $display("FAIL pad_frame_len: got %0d want 72", run_len(fs)); end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (tr_data[base + 8 + i] !== pay[i]) begin
        errors++; $display("FAIL pad_payload[%0d]: got %h want %h", i, tr_data[base + 8 + i], pay[i]);
      end
    end
    checks++; if (count_zero(base + 22, 46) != 46) begin
      errors++; $display("FAIL pad_zero_bytes: got %0d want 46", count_zero(base + 22, 46));
    end
    r = residue(base + 8, 64);
    checks++; if (r !== 32'hDEBB20E3) begin errors++; $display("FAIL pad_residue: got %h want DEBB20E3", r); end
    checks++; if (count_er() != 0) begin errors++; $display("FAIL pad_tx_er: high %0d cycles want 0", count_er()); end
    $display("test_pad done: checks %0d errors %0d", checks, errors);
  endtask

  task automatic test_min_length();
    int lens[3] = '{1, 59, 60};
    bit ok1, ok2;
    int fs, base, l;
    logic [31:0] r;
    for (int k = 0; k < 3; k++) begin
      l = lens[k];
      clear_all();
      load_frame(l, 8'(8'h80 + k));
      send_stream(0, ok1);
      wait_idle(ok2);
      checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL min%0d_timeout: send %b idle %b want 1 1", l, ok1, ok2); end
      fs = first_en(0);
      base = (fs < 0) ? 0 : fs;
      checks++; if (run_len(fs) != 72) begin errors++; $display("FAIL min%0d_frame_len: got %0d want 72", l, run_len(fs)); end
      checks++; if (tr_data[base + 7 + l] !== pay[l - 1]) begin
        errors++; $display("FAIL min%0d_last_byte: got %h want %h", l, tr_data[base + 7 + l], pay[l - 1]);
      end
      checks++; if (count_zero(base + 8 + l, 60 - l) != 60 - l) begin
        errors++; $display("FAIL min%0d_pad: got %0d zeros want %0d", l, count_zero(base + 8 + l, 60 - l), 60 - l);
      end
      r = residue(base + 8, 64);
      checks++; if (r !== 32'hDEBB20E3) begin errors++; $display("FAIL min%0d_residue: got %h want DEBB20E3", l, r); end
    end
    $display("test_min_length done: checks %0d errors %0d", checks, errors);
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int f1, r1, f2, r2, b1, b2, rdy_hits;
    logic [31:0] ra, rb;
    clear_all();
    load_frame(64, 8'h21);
    load_frame(64, 8'h5A);
    send_stream(0, ok1);
    wait_idle(ok2);
    checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL b2b_timeout: send %b idle %b want 1 1", ok1, ok2); end
    f1 = first_en(0);
    r1 = run_len(f1);
    b1 = (f1 < 0) ? 0 : f1;
    f2 = first_en(b1 + r1);
    r2 = run_len(f2);
    b2 = (f2 < 0) ? 0 : f2;
    checks++; if (r1 != 76) begin errors++; $display("FAIL b2b_len1: got %0d want 76", r1); end
    checks++; if (r2 != 76) begin errors++; $display("FAIL b2b_len2: got %0d want 76", r2); end
    checks++; if (f2 - (b1 + r1) != 12) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles want 12", f2 - (b1 + r1)); end
    checks++; if (tr_data[b2] !== 8'h55) begin errors++; $display("FAIL b2b_second_pre: got %h want 55", tr_data[b2]); end
    rdy_hits = 0;
    for (int i = b1; i < b1 + 7; i++) if (tr_rdy[i]) rdy_hits++;
    for (int i = b1 + r1; i < b2 + 7; i++) if (tr_rdy[i]) rdy_hits++;
    checks++; if (rdy_hits != 0) begin errors++; $display("FAIL b2b_ready_pre_ipg: high %0d cycles want 0", rdy_hits); end
    checks++; if (tr_rdy[b2 + 7] !== 1'b1) begin errors++; $display("FAIL b2b_ready_sfd: got %b want 1", tr_rdy[b2 + 7]); end
    ra = residue(b1 + 8, 68);
    rb = residue(b2 + 8, 68);
    checks++; if (ra !== 32'hDEBB20E3) begin errors++; $display("FAIL b2b_residue1: got %h want DEBB20E3", ra); end
    checks++; if (rb !== 32'hDEBB20E3) begin errors++; $display("FAIL b2b_residue2: got %h want DEBB20E3", rb); end
    $display("test_back_to_back done: checks %0d errors %0d", checks, errors);
  endtask

  task automatic test_underrun();
    bit ok1, ok2;
    int fs, base, rl;
    clear_all();
    load_frame(30, 8'h33);
    send_stream(20, ok1);
    set_valid(1'b0);
    in_last = 1'b0;
    wait_idle(ok2);
    checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL undr_timeout: send %b idle %b want 1 1", ok1, ok2); end
    fs = first_en(0);
    base = (fs < 0) ? 0 : fs;
    rl = run_len(fs);
    checks++; if (rl != 29) begin errors++; $display("FAIL undr_frame_len: got %0d want 29", rl); end
    checks++; if (tr_data[base + 27] !== pay[19]) begin
      errors++; $display("FAIL undr_last_data: got %h want %h", tr_data[base + 27], pay[19]);
    end
    checks++; if (tr_er[base + 28] !== 1'b1 || tr_data[base + 28] !== 8'h00) begin
      errors++; $display("FAIL undr_err_byte: tx_er %b tx_data %h want 1 00", tr_er[base + 28], tr_data[base + 28]);
    end
    checks++; if (count_er() != 1) begin errors++; $display("FAIL undr_er_count: got %0d want 1", count_er()); end
    checks++; if (first_en(base + rl) != -1) begin
      errors++; $display("FAIL undr_no_fcs: tx_en seen again at %0d want none", first_en(base + rl));
    end
    $display("test_underrun done: checks %0d errors %0d", checks, errors);
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2;
    int fs;
    logic [31:0] r;
    clear_all();
    load_frame(30, 8'h44);
    send_stream(10, ok1);
    checks++; if (m_en !== 1'b1 || m_data !== pay[9]) begin
      errors++; $display("FAIL rstmid_before: tx_en %b tx_data %h want 1 %h", m_en, m_data, pay[9]);
    end
    rst_n = 1'b0;
    set_valid(1'b0);
    in_last = 1'b0;
    #1;
    checks++; if (m_en !== 1'b0 || m_ready !== 1'b0 || m_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: tx_en %b in_ready %b busy %b want 0 0 0", m_en, m_ready, m_busy);
    end
    checks++; if (m_data !== 8'h00 || m_er !== 1'b0) begin
      errors++; $display("FAIL rstmid_data: tx_data %h tx_er %b want 00 0", m_data, m_er);
    end
    rec = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (m_busy !== 1'b0 || m_en !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: busy %b tx_en %b want 0 0", m_busy, m_en);
    end
    clear_all();
    load_frame(14, 8'hC0);
    send_stream(0, ok1);
    wait_idle(ok2);
    checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL rstmid_timeout: send %b idle %b want 1 1", ok1, ok2); end
    fs = first_en(0);
    checks++; if (run_len(fs) != 72) begin errors++; $display("FAIL rstmid_frame_len: got %0d want 72", run_len(fs)); end
    r = residue(((fs < 0) ? 0 : fs) + 8, 64);
    checks++; if (r !== 32'hDEBB20E3) begin errors++; $display("FAIL rstmid_residue: got %h want DEBB20E3", r); end
    $display("test_reset_mid done: checks %0d errors %0d", checks, errors);
  endtask

  initial begin
    sel_np = 1'b0;
    rec = 1'b0;
    test_reset();
    test_crc_check();
    test_pad();
    test_min_length();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Byte-wide Ethernet transmit framer. Sits upstream of the MAC TX pins and consumes a payload byte stream from the packet source (destination MAC through end of payload). It emits a complete MII/GMII-style byte stream:

- preamble and SFD
- payload, zero-padded to the minimum frame length
- 4-byte FCS (CRC-32)
- enforced inter-packet gap

The FCS is chosen so that a receiver running the team's CRC-32 checker over payload+pad+FCS ends with residue 0xDEBB20E3.

## Interface
Parameters:
- MIN_FRAME, 60: minimum bytes before FCS; shorter frames are padded with 0x00. 0 disables padding.
- IPG_BYTES, 12: idle cycles forced between frames, range 1..255.

Ports:
- clk  in  1  sole clock; one byte per cycle.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  source has a payload byte.
- in_data  in  8  payload byte.
- in_last  in  1  marks the final payload byte; qualified by in_valid & in_ready.
- in_ready  out  1  framer accepts the byte this cycle.
- tx_en  out  1  frame byte on tx_data is valid.
- tx_er  out  1  error marker; asserted on underrun.
- tx_data  out  8  line byte.
- busy  out  1  high in any state other than IDLE.

## Operation
- Reset values: tx_en=0, tx_er=0, tx_data=0x00, in_ready=0, busy=0, state=IDLE, crc=0xFFFFFFFF, counters=0.
- tx_en, tx_er and tx_data are registered. There is no downstream backpressure; the framer advances every cycle once a frame starts.
- The state register names what tx_data currently carries. States:
  - IDLE
  - PRE: 7 × 0x55
  - SFD: 0xD5
  - DATA
  - PAD: 0x00
  - FCS: 4 bytes
  - UNDR: one byte, 0x00 with tx_er=1
  - IPG
- IDLE→PRE when in_valid=1; the byte is not consumed.
- PRE→SFD after the 7th 0x55.
- in_ready = (state==SFD) | (state==DATA & ~last_taken). The output is combinational from registered state only; it never depends on in_valid.
- A beat accepted in cycle N appears on tx_data in cycle N+1.
- SFD or DATA with in_ready & in_valid → DATA.
- SFD or DATA with in_ready & ~in_valid → UNDR (underrun), then IPG. The FCS is not sent.
- After the byte flagged in_last, the next state is chosen as follows:
  - PAD if byte_count < MIN_FRAME; PAD repeats until byte_count == MIN_FRAME, then FCS.
  - otherwise FCS.
- FCS → IPG after byte 3. IPG → IDLE after IPG_BYTES cycles with tx_en=0.
- in_valid is ignored during IPG, so back-to-back frames are separated by exactly IPG_BYTES idle cycles.
- CRC: reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, updated on every DATA and PAD byte, LSB-first.
  - FCS value = ~crc; bytes are sent fcs[7:0], fcs[15:8], fcs[23:16], fcs[31:24].
  - The CRC reinitialises on entry to PRE.
- byte_count: 11 bits, counts DATA+PAD bytes, saturates at 2047. There is no maximum-length enforcement.

## Timing
- Latency: in_valid rising in IDLE → tx_en=1 with 0x55 on the next cycle. SFD is on tx_data 7 cycles later.
- Frame duration with tx_en high: 8 + max(payload, MIN_FRAME) + 4 cycles.
- An underrun frame lasts 8 + accepted bytes + 1 cycles, with tx_er high only on the last of those cycles.
- rst_n low mid-frame: all outputs drop to reset values immediately (asynchronously). No FCS or IPG is emitted. After release the framer starts in IDLE.
- in_last on the first accepted byte is a legal 1-byte payload.
- in_last arriving when byte_count == MIN_FRAME-1 goes straight to FCS, with no PAD.

## Structure
- Package eth_pkg holds:
  - the state enum;
  - constants ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, ETH_CRC_POLY=32'hEDB88320, ETH_CRC_INIT=32'hFFFFFFFF, ETH_CRC_RESIDUE=32'hDEBB20E3.
- One sub-module, eth_tx_crc8: byte-parallel CRC-32 update with clk, rst_n, init, en, din[7:0] and crc[31:0]. It has the same async active-low reset as the framer.
- The framer FSM, counters and output mux live in the top module.

## Test plan
- MIN_FRAME=0, payload ASCII "123456789" → tx_data sequence 55×7, D5, 31..39, then FCS bytes 26 39 F4 CB; tx_en high for 21 cycles; tx_er never high.
- Default parameters, 14-byte payload → 46 bytes of 0x00 PAD, 72 tx_en cycles; a checker CRC over bytes 9..72 (payload+pad+FCS) gives residue 0xDEBB20E3.
- Two 64-byte frames with in_valid held high → exactly 12 tx_en=0 cycles between the last FCS byte and the next 0x55; in_ready=0 throughout PRE and IPG.
- in_valid dropped after 20 accepted bytes → one cycle of tx_en=1, tx_er=1, tx_data=0x00, then IPG; no FCS bytes.
- rst_n pulsed low during the 10th payload byte → tx_en, in_ready and busy go to 0 within the same cycle; the next frame after release is framed and checksummed correctly.
- 1-byte payload with in_last on the first beat → pad to 60 bytes, correct FCS.
